// File: rtl/decoder_pkg.sv
// Shared decode definitions for the load/store path.
//   LDST_*       : funct3 size codes seen on core_size_i.
//   ldst_size_e  : access width class, after folding signedness and illegal codes.
//   size_of()    : maps a funct3 size code to its width class.
//                  Illegal codes (3, 6, 7) are treated as a word.
//   is_unsigned(): 1 for the zero-extending load codes.
package decoder_pkg;

  localparam logic [2:0] LDST_B  = 3'd0;
  localparam logic [2:0] LDST_H  = 3'd1;
  localparam logic [2:0] LDST_W  = 3'd2;
  localparam logic [2:0] LDST_BU = 3'd4;
  localparam logic [2:0] LDST_HU = 3'd5;

  typedef enum logic [1:0] {
    SIZE_BYTE,
    SIZE_HALF,
    SIZE_WORD
  } ldst_size_e;

  function automatic ldst_size_e size_of(input logic [2:0] code);
    case (code)
      LDST_B, LDST_BU: return SIZE_BYTE;
      LDST_H, LDST_HU: return SIZE_HALF;
      default:         return SIZE_WORD;
    endcase
  endfunction

  function automatic logic is_unsigned(input logic [2:0] code);
    return (code == LDST_BU) || (code == LDST_HU);
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data formatter (purely combinational).
//   rd   in  32  raw word returned by data_mem
//   size in  3   funct3 size code of the load
//   off  in  2   byte offset of the load within the word
//   data out 32  selected byte/half, sign- or zero-extended; words pass through
module lsu_load_align
  import decoder_pkg::*;
(
  input  logic [31:0] rd,
  input  logic [2:0]  size,
  input  logic [1:0]  off,
  output logic [31:0] data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic        zext;

  assign byte_v = rd[{off, 3'b000} +: 8];
  assign half_v = rd[{off[1], 4'b0000} +: 16];
  assign zext   = is_unsigned(size);

  // NOTE: data gets a default before the case so no path can leave it
  // unassigned; a missing default here would infer a latch.
  always_comb begin
    data = rd;
    case (size_of(size))
      SIZE_BYTE: data = zext ? {24'h0, byte_v} : {{24{byte_v[7]}}, byte_v};
      SIZE_HALF: data = zext ? {16'h0, half_v} : {{16{half_v[15]}}, half_v};
      default:   data = rd;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit between the core datapath and data_mem.
//   clk_i, rst_i        clock; asynchronous active-high reset
//   core_req_i/we_i     core load/store request (held while core_stall_o=1)
//   core_size_i         funct3 size code; core_addr_i byte address; core_wd_i store data
//   core_rd_o           aligned, extended load data (valid on the completing cycle)
//   core_stall_o        core must hold its request
//   core_misaligned_o   request is misaligned and is not issued
//   core_fault_o        one-cycle pulse when the memory never became ready
//   mem_*_o             word-aligned request to data_mem with byte enables and
//                       lane-replicated write data
//   mem_rd_i            read data, valid one cycle after the request
//   mem_ready_i         data_mem ready
// TIMEOUT_CYCLES: BUSY cycles with mem_ready_i low before a fault (0 = never).
module lsu
  import decoder_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [2:0]  core_size_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wd_i,
  output logic [31:0] core_rd_o,
  output logic        core_stall_o,
  output logic        core_misaligned_o,
  output logic        core_fault_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
  input  logic [31:0] mem_rd_i,
  input  logic        mem_ready_i
);

  typedef enum logic {IDLE, BUSY} lsu_state_t;

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
  localparam logic TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

  lsu_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       size_q;
  logic [1:0]       off_q;

  ldst_size_e  cls;
  logic [1:0]  off;
  logic        misaligned;
  logic        capture;
  logic        issue;
  logic        stall;
  logic        fault;
  logic        rd_valid;
  logic [3:0]  be;
  logic [31:0] wd_rep;
  logic [31:0] rd_aligned;

  assign cls = size_of(core_size_i);
  assign off = core_addr_i[1:0];

  assign misaligned = core_req_i &&
                      (((cls == SIZE_HALF) && off[0]) ||
                       ((cls == SIZE_WORD) && (off != 2'b00)));

  always_comb begin
    be     = 4'b1111;
    wd_rep = core_wd_i;
    case (cls)
      SIZE_BYTE: begin
        be     = 4'b0001 << off;
        wd_rep = {4{core_wd_i[7:0]}};
      end
      SIZE_HALF: begin
        be     = 4'b0011 << off;
        wd_rep = {2{core_wd_i[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    capture  = 1'b0;
    issue    = 1'b0;
    stall    = 1'b0;
    fault    = 1'b0;
    rd_valid = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (core_req_i && !misaligned) begin
          issue   = 1'b1;
          stall   = 1'b1;
          capture = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        // Re-issuing while waiting is harmless: the core holds address and data.
        issue = core_req_i;
        if (mem_ready_i) begin
          rd_valid = 1'b1;
          state_d  = IDLE;
          cnt_d    = '0;
        end else if (TIMEOUT_EN && (cnt_q == CNT_LAST)) begin
          fault   = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          stall = 1'b1;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: every register here is non-blocking so all of them update from the
  // same pre-edge values, matching what the combinational block computed.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      size_q  <= '0;
      off_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (capture) begin
        size_q <= core_size_i;
        off_q  <= off;
      end
    end
  end

  // Formatting uses the size/offset captured at issue, not the live request.
  lsu_load_align u_align (
    .rd   (mem_rd_i),
    .size (size_q),
    .off  (off_q),
    .data (rd_aligned)
  );

  assign mem_req_o  = issue;
  assign mem_we_o   = issue & core_we_i;
  assign mem_be_o   = issue ? be : 4'b0000;
  assign mem_addr_o = issue ? {core_addr_i[31:2], 2'b00} : 32'h0;
  assign mem_wd_o   = issue ? wd_rep : 32'h0;

  assign core_misaligned_o = misaligned;
  assign core_stall_o      = stall & core_req_i;
  assign core_fault_o      = fault & core_req_i;
  assign core_rd_o         = (rd_valid && core_req_i && !core_we_i) ? rd_aligned : 32'h0;

endmodule

// File: tb/tb_lsu.sv
module tb_lsu;
  import decoder_pkg::*;

  localparam int unsigned TO = 4;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        core_req_i;
  logic        core_we_i;
  logic [2:0]  core_size_i;
  logic [31:0] core_addr_i;
  logic [31:0] core_wd_i;
  logic [31:0] core_rd_o;
  logic        core_stall_o;
  logic        core_misaligned_o;
  logic        core_fault_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wd_o;
  logic [31:0] mem_rd_i;
  logic        mem_ready_i;

  lsu #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .core_req_i        (core_req_i),
    .core_we_i         (core_we_i),
    .core_size_i       (core_size_i),
    .core_addr_i       (core_addr_i),
    .core_wd_i         (core_wd_i),
    .core_rd_o         (core_rd_o),
    .core_stall_o      (core_stall_o),
    .core_misaligned_o (core_misaligned_o),
    .core_fault_o      (core_fault_o),
    .mem_req_o         (mem_req_o),
    .mem_we_o          (mem_we_o),
    .mem_be_o          (mem_be_o),
    .mem_addr_o        (mem_addr_o),
    .mem_wd_o          (mem_wd_o),
    .mem_rd_i          (mem_rd_i),
    .mem_ready_i       (mem_ready_i)
  );

  always #5 clk_i = ~clk_i;

  // data_mem stand-in: 64 words, read data appears one cycle after a request.
  logic [31:0] init_words [64];
  logic [31:0] emu_mem    [64];
  logic [31:0] mem_rd_q;
  logic [31:0] wr_word;
  logic        seed_mem;

  always @(posedge clk_i) begin
    if (seed_mem) begin
      emu_mem <= init_words;
    end else if (mem_req_o) begin
      if (mem_we_o) begin
        wr_word = emu_mem[mem_addr_o[7:2]];
        for (int b = 0; b < 4; b++)
          if (mem_be_o[b]) wr_word[8*b +: 8] = mem_wd_o[8*b +: 8];
        emu_mem[mem_addr_o[7:2]] <= wr_word;
      end else begin
        mem_rd_q <= emu_mem[mem_addr_o[7:2]];
      end
    end
  end
  assign mem_rd_i = mem_rd_q;

  // Reference model: a flat byte array with little-endian access rules.
  logic [7:0] ref_mem [256];
  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic int nbytes(input logic [2:0] s);
    if (s == 3'd0 || s == 3'd4) return 1;
    if (s == 3'd1 || s == 3'd5) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] s, input logic [31:0] addr);
    logic [31:0] v;
    int n;
    n = nbytes(s);
    v = 0;
    for (int i = 0; i < n; i++)
      v = v | (32'(ref_mem[(addr + i) & 255]) << (8 * i));
    if (s == 3'd0 && v[7])  v = v | 32'hFFFF_FF00;
    if (s == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  // One core access; delay = BUSY cycles with ready low before ready rises.
  task automatic access(input string name, input logic we, input logic [2:0] size,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input int delay, output logic [31:0] rd_got);
    int n, cycles, stall_cycles, fault_cycles, exp_cycles;
    logic mis, done, timed_out;
    logic [3:0] exp_be;
    logic [31:0] exp_wd;
    n = nbytes(size);
    mis = (n == 2 && addr[0]) || (n == 4 && addr[1:0] != 2'b00);
    timed_out = !mis && (delay >= int'(TO));
    exp_be = 4'(((1 << n) - 1) << addr[1:0]);
    for (int i = 0; i < 4; i++) exp_wd[8*i +: 8] = wd[8*(i % n) +: 8];
    core_req_i = 1'b1; core_we_i = we; core_size_i = size;
    core_addr_i = addr; core_wd_i = wd;
    cycles = 0; stall_cycles = 0; fault_cycles = 0; done = 1'b0; rd_got = 32'h0;
    while (!done && cycles < 40) begin
      mem_ready_i = (cycles + 1 >= delay + 2);
      @(negedge clk_i);
      cycles++;
      if (cycles == 1) begin
        check({name, " misaligned"}, 32'(core_misaligned_o), 32'(mis));
        check({name, " mem_req"}, 32'(mem_req_o), 32'(!mis));
        if (!mis) begin
          check({name, " mem_we"}, 32'(mem_we_o), 32'(we));
          check({name, " mem_addr"}, mem_addr_o, {addr[31:2], 2'b00});
          check({name, " mem_be"}, 32'(mem_be_o), 32'(exp_be));
          check({name, " mem_wd"}, mem_wd_o, exp_wd);
        end
      end
      if (core_stall_o) stall_cycles++;
      if (core_fault_o) fault_cycles++;
      if (!core_stall_o) begin
        done = 1'b1;
        rd_got = core_rd_o;
      end
      @(posedge clk_i);
      #1;
    end
    exp_cycles = mis ? 1 : (timed_out ? int'(TO) + 1 : delay + 2);
    check({name, " cycles"}, 32'(cycles), 32'(exp_cycles));
    check({name, " stall cycles"}, 32'(stall_cycles), 32'(exp_cycles - 1));
    check({name, " fault pulses"}, 32'(fault_cycles), 32'(timed_out));
    if (!we && !mis)
      check({name, " rd"}, rd_got, timed_out ? 32'h0 : ref_load(size, addr));
    if (we && !mis && !timed_out)
      for (int i = 0; i < n; i++) ref_mem[(addr + i) & 255] = wd[8*i +: 8];
    core_req_i = 1'b0;
    mem_ready_i = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] r;
    logic [2:0]  sz;
    logic [31:0] a;
    rst_i = 1'b1; seed_mem = 1'b1; mem_ready_i = 1'b1;
    core_req_i = 1'b0; core_we_i = 1'b0; core_size_i = 3'd0;
    core_addr_i = 32'h0; core_wd_i = 32'h0;
    for (int w = 0; w < 64; w++) begin
      init_words[w] = $urandom;
      for (int b = 0; b < 4; b++) ref_mem[4*w + b] = init_words[w][8*b +: 8];
    end
    repeat (3) @(posedge clk_i);
    #1 seed_mem = 1'b0;
    @(negedge clk_i);
    check("reset outputs", {core_rd_o ^ mem_addr_o ^ mem_wd_o},  32'h0);
    check("reset flags", {26'h0, core_stall_o, core_fault_o, core_misaligned_o,
                          mem_req_o, mem_we_o, |mem_be_o}, 32'h0);
    @(posedge clk_i);
    #1 rst_i = 1'b0;

    // Async reset while BUSY.
    core_req_i = 1'b1; core_we_i = 1'b0; core_size_i = LDST_W; core_addr_i = 32'h40;
    mem_ready_i = 1'b0;
    @(negedge clk_i);
    check("rst pre stall", 32'(core_stall_o), 32'h1);
    @(posedge clk_i);
    #2 rst_i = 1'b1;
    #1 core_req_i = 1'b0;
    #1 check("rst idle flags", {29'h0, core_stall_o, core_fault_o, mem_req_o}, 32'h0);
    mem_ready_i = 1'b1; core_req_i = 1'b1;
    #1 check("rst state idle", 32'(core_stall_o), 32'h1);
    core_req_i = 1'b0;
    @(posedge clk_i);
    #1 rst_i = 1'b0;

    // Word store / load.
    access("SW 0x10", 1'b1, LDST_W, 32'h10, 32'hDEAD_BEEF, 0, r);
    access("LW 0x10", 1'b0, LDST_W, 32'h10, 32'h0, 0, r);
    check("LW 0x10 const", r, 32'hDEAD_BEEF);

    // Byte store / loads.
    access("SB 0x13", 1'b1, LDST_B, 32'h13, 32'h0000_00A5, 0, r);
    access("LB 0x13", 1'b0, LDST_B, 32'h13, 32'h0, 0, r);
    check("LB 0x13 const", r, 32'hFFFF_FFA5);
    access("LBU 0x13", 1'b0, LDST_BU, 32'h13, 32'h0, 0, r);
    check("LBU 0x13 const", r, 32'h0000_00A5);

    // Half store / loads and misaligned requests.
    access("SH 0x22", 1'b1, LDST_H, 32'h22, 32'h0000_8001, 0, r);
    access("LH 0x22", 1'b0, LDST_H, 32'h22, 32'h0, 0, r);
    check("LH 0x22 const", r, 32'hFFFF_8001);
    access("LHU 0x22", 1'b0, LDST_HU, 32'h22, 32'h0, 0, r);
    check("LHU 0x22 const", r, 32'h0000_8001);
    access("LH 0x21", 1'b0, LDST_H, 32'h21, 32'h0, 0, r);
    access("SW 0x12", 1'b1, LDST_W, 32'h12, 32'h1234_5678, 0, r);
    access("LW 0x10 after mis", 1'b0, LDST_W, 32'h10, 32'h0, 0, r);

    // Timeout and the longest wait that still completes.
    access("LW timeout", 1'b0, LDST_W, 32'h30, 32'h0, 100, r);
    access("LW after timeout", 1'b0, LDST_W, 32'h30, 32'h0, 0, r);
    access("LW delay 3", 1'b0, LDST_W, 32'h34, 32'h0, 3, r);
    access("LBU delay 1", 1'b0, LDST_BU, 32'h35, 32'h0, 1, r);

    // Back-to-back accesses; captured offset must not leak into the next one.
    access("LBU 0x3", 1'b0, LDST_BU, 32'h3, 32'h0, 0, r);
    access("LW 0x0", 1'b0, LDST_W, 32'h0, 32'h0, 0, r);
    access("LW 0x4", 1'b0, LDST_W, 32'h4, 32'h0, 0, r);

    // Illegal size codes behave as words.
    access("SW size6", 1'b1, 3'd6, 32'h50, 32'hCAFE_F00D, 0, r);
    access("LW size3", 1'b0, 3'd3, 32'h50, 32'h0, 0, r);
    access("LW size7", 1'b0, 3'd7, 32'h52, 32'h0, 0, r);

    // Random traffic.
    for (int k = 0; k < 60; k++) begin
      case ($urandom_range(0, 7))
        0: sz = LDST_B;  1: sz = LDST_H;  2: sz = LDST_W;
        3: sz = LDST_BU; 4: sz = LDST_HU; 5: sz = 3'd3;
        6: sz = LDST_W;  default: sz = 3'd7;
      endcase
      a = 32'($urandom_range(0, 252));
      if ($urandom_range(0, 3) != 0) a = a & ~((nbytes(sz) == 4) ? 32'h3 :
                                               (nbytes(sz) == 2) ? 32'h1 : 32'h0);
      access("rand", 1'($urandom_range(0, 1)), sz, a, $urandom,
             int'($urandom_range(0, 2)), r);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
